// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
//   Shared types and constants for the memory responder slice.
//   mem_port_t    : which CPU memory port owns the current transaction
//   mresp_state_t : responder FSM states
//   MRESP_CNT_W   : width of the latency down-counter (covers LATENCY up to 15)
package mem_responder_pkg;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } mem_port_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mresp_state_t;

  localparam int MRESP_CNT_W = 4;

endpackage

// File: rtl/mem_responder_arb.sv
// mem_responder_arb
//   Combinational grant between the fetch port and the load/store port.
//   Optional macro: MEMRESP_ROUND_ROBIN_EN
//     undefined : dmem has fixed priority over imem
//     defined   : on a tie, the port not granted last wins
// Ports:
//   imem_req    in  fetch request pending
//   dmem_req    in  load/store request pending
//   last_grant  in  port granted most recently (round-robin build only)
//   grant_valid out at least one request is pending
//   grant       out port selected this cycle (meaningful when grant_valid=1)
module mem_responder_arb
  import mem_responder_pkg::*;
(
  input  logic      imem_req,
  input  logic      dmem_req,
`ifdef MEMRESP_ROUND_ROBIN_EN
  input  mem_port_t last_grant,
`endif
  output logic      grant_valid,
  output mem_port_t grant
);

  assign grant_valid = imem_req | dmem_req;

`ifdef MEMRESP_ROUND_ROBIN_EN
  // A tie goes to whichever port did not win last time; a lone requester always wins.
  always_comb begin
    grant = PORT_I;
    if (imem_req && dmem_req) begin
      grant = (last_grant == PORT_D) ? PORT_I : PORT_D;
    end else if (dmem_req) begin
      grant = PORT_D;
    end
  end
`else
  // Fixed priority: a pending load/store always beats a fetch.
  always_comb begin
    grant = dmem_req ? PORT_D : PORT_I;
  end
`endif

endmodule

// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the CPU fetch (imem) and load/store (dmem) ports.
//   One single-ported word array is shared by both ports; requests are serialised
//   by mem_responder_arb and each accepted request gets one resp pulse LATENCY
//   cycles after acceptance. Stores commit at the edge that ends the resp cycle.
//   Optional macro: MEMRESP_ROUND_ROBIN_EN (round-robin arbitration with a
//   last-grant register instead of fixed dmem priority).
// Parameters:
//   ADDR_BITS  word-index width (array holds 2**ADDR_BITS words, at most 30)
//   BASE_ADDR  byte address of word 0
//   LATENCY    cycles from acceptance edge to resp cycle, 1..15
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_addr/rmask          fetch request; rdata/resp returned
//   dmem_addr/rmask/wmask/wdata  load/store request; rdata/resp returned
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          ADDR_BITS = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [MRESP_CNT_W-1:0] CNT_INIT = MRESP_CNT_W'(LATENCY - 1);

  logic [31:0] mem [DEPTH];

  mresp_state_t         state;
  logic [MRESP_CNT_W-1:0] count;

  // Transaction captured at acceptance
  mem_port_t            port_q;
  logic [ADDR_BITS-1:0] idx_q;
  logic                 in_range_q;
  logic [3:0]           wmask_q;
  logic [31:0]          wdata_q;

  logic      imem_req, dmem_req, any_req;
  mem_port_t grant;

`ifdef MEMRESP_ROUND_ROBIN_EN
  mem_port_t last_grant;
`endif

  assign imem_req = (imem_rmask != 4'h0);
  assign dmem_req = ((dmem_rmask | dmem_wmask) != 4'h0);

  mem_responder_arb u_arb (
    .imem_req    (imem_req),
    .dmem_req    (dmem_req),
`ifdef MEMRESP_ROUND_ROBIN_EN
    .last_grant  (last_grant),
`endif
    .grant_valid (any_req),
    .grant       (grant)
  );

  // Address decode of the granted port. The low two byte-offset bits are
  // deliberately ignored; they only feed the unused_* sink.
  logic [31:0]          sel_addr, offset;
  logic                 sel_in_range;
  logic [ADDR_BITS-1:0] sel_idx;
  logic                 unused_offset_bits;

  assign sel_addr           = (grant == PORT_D) ? dmem_addr : imem_addr;
  assign offset             = sel_addr - BASE_ADDR;
  assign sel_in_range       = (sel_addr >= BASE_ADDR) && ((offset[31:2] >> ADDR_BITS) == '0);
  assign sel_idx            = offset[ADDR_BITS+1:2];
  assign unused_offset_bits = ^offset[1:0];

  // The transaction whose data goes out next: with LATENCY=1 the resp cycle
  // follows IDLE directly, so the live decode is used instead of the latched one.
  mem_port_t            resp_port;
  logic [ADDR_BITS-1:0] resp_idx;
  logic                 resp_in_range;
  logic [31:0]          read_word;
  logic                 accept, enter_resp;

  always_comb begin
    resp_port     = port_q;
    resp_idx      = idx_q;
    resp_in_range = in_range_q;
    if (state == IDLE) begin
      resp_port     = grant;
      resp_idx      = sel_idx;
      resp_in_range = sel_in_range;
    end
  end

  assign read_word  = resp_in_range ? mem[resp_idx] : 32'h0;
  assign accept     = (state == IDLE) && any_req;
  assign enter_resp = (accept && (LATENCY == 1)) || ((state == BUSY) && (count == MRESP_CNT_W'(1)));

  // Capture the granted request's decode, masks and data when it is accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      port_q     <= grant;
      idx_q      <= sel_idx;
      in_range_q <= sel_in_range;
      wmask_q    <= (grant == PORT_D) ? dmem_wmask : 4'h0;
      wdata_q    <= dmem_wdata;
    end
  end

  // Store commit at the edge ending RESP. Reset cancels a pending store, and
  // out-of-range stores are dropped. Fetches carry a zero wmask.
  always_ff @(posedge clk) begin
    if (!rst && (state == RESP) && in_range_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask_q[i]) begin
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  // FSM, latency counter and registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      imem_resp  <= 1'b0;
      dmem_resp  <= 1'b0;
      imem_rdata <= 32'h0;
      dmem_rdata <= 32'h0;
`ifdef MEMRESP_ROUND_ROBIN_EN
      last_grant <= PORT_I;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
`ifdef MEMRESP_ROUND_ROBIN_EN
            last_grant <= grant;
`endif
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= BUSY;
              count <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          count <= count - 1'b1;
          if (count == MRESP_CNT_W'(1)) begin
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // rdata is the pre-store word: the array is read before the commit edge.
      if (enter_resp) begin
        imem_resp  <= (resp_port == PORT_I);
        dmem_resp  <= (resp_port == PORT_D);
        imem_rdata <= (resp_port == PORT_I) ? read_word : 32'h0;
        dmem_rdata <= (resp_port == PORT_D) ? read_word : 32'h0;
      end else if (state == RESP) begin
        imem_resp  <= 1'b0;
        dmem_resp  <= 1'b0;
        imem_rdata <= 32'h0;
        dmem_rdata <= 32'h0;
      end
    end
  end

endmodule
